// File: rtl/settings_host_bridge.sv
`timescale 1ns/1ps
// settings_host_bridge
// Byte-stream master for the settings memory. Decodes framed host commands
// (CMD, ADDR, then NB data bytes MSB first for writes) into read/write cycles
// on the settings port and returns a STATUS byte, followed by the read word
// (MSB first) for a successful read.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rx_data/valid/ready    command byte stream from the host
//   tx_data/valid/ready    response byte stream to the host
//   addr, wen, data_in     settings address, write strobe, write data
//   data_out               settings read data (READ_LATENCY cycles after addr)
//   busy                   high whenever the bridge is not idle
module settings_host_bridge #(
  parameter int MEMORY_WIDTH      = 32,
  parameter int ROM_MEMORY_LENGTH = 16,
  parameter int RAM_MEMORY_LENGTH = 16,
  parameter int READ_LATENCY      = 1,
  localparam int TOTAL      = ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH,
  localparam int ADDR_WIDTH = $clog2(TOTAL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    wen,
  output logic [MEMORY_WIDTH-1:0] data_in,
  input  logic [MEMORY_WIDTH-1:0] data_out,
  output logic                    busy
);

  localparam int NB = MEMORY_WIDTH / 8;

  localparam logic [7:0] CMD_RD      = 8'h01;
  localparam logic [7:0] CMD_WR      = 8'h02;
  localparam logic [7:0] ST_OK       = 8'hA0;
  localparam logic [7:0] ST_BAD_CMD  = 8'hE1;
  localparam logic [7:0] ST_BAD_ADDR = 8'hE2;
  localparam logic [7:0] ST_ROM      = 8'hE3;

  localparam logic [7:0] LAST_BYTE = 8'(NB - 1);
  localparam logic [7:0] LAT_LAST  = (READ_LATENCY > 0) ? 8'(READ_LATENCY - 1) : 8'd0;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    WAIT_RD,
    SEND_STATUS,
    SEND_DATA
  } state_t;

  state_t                  state;
  logic [7:0]              addr_byte;
  logic                    is_write;
  logic                    rd_ok;
  logic [7:0]              cnt;
  logic [MEMORY_WIDTH-1:0] shreg;
  logic [MEMORY_WIDTH-1:0] shreg_next;
  logic [7:0]              exec_status;
  logic                    rx_xfer;

  // Range check takes priority over the ROM-write check.
  function automatic logic [7:0] addr_status(input logic [7:0] a, input logic wr);
    if ({1'b0, a} >= 9'(TOTAL))
      return ST_BAD_ADDR;
    else if (wr && ({1'b0, a} < 9'(ROM_MEMORY_LENGTH)))
      return ST_ROM;
    else
      return ST_OK;
  endfunction

  assign rx_xfer     = rx_valid && rx_ready;
  assign shreg_next  = (shreg << 8) | MEMORY_WIDTH'(rx_data);
  assign exec_status = addr_status(addr_byte, is_write);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      addr      <= '0;
      data_in   <= '0;
      wen       <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      addr_byte <= '0;
      is_write  <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      wen <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          rd_ok    <= 1'b0;
          if (rx_xfer) begin
            if (rx_data == CMD_RD || rx_data == CMD_WR) begin
              is_write <= (rx_data == CMD_WR);
              state    <= GET_ADDR;
            end else begin
              rx_ready <= 1'b0;
              tx_data  <= ST_BAD_CMD;
              tx_valid <= 1'b1;
              state    <= SEND_STATUS;
            end
          end
        end

        GET_ADDR: begin
          if (rx_xfer) begin
            addr_byte <= rx_data;
            cnt       <= '0;
            if (is_write) begin
              state <= GET_DATA;
            end else begin
              rx_ready <= 1'b0;
              state    <= EXEC;
              // addr must already be valid during EXEC for the read
              if (addr_status(rx_data, 1'b0) == ST_OK)
                addr <= rx_data[ADDR_WIDTH-1:0];
            end
          end
        end

        GET_DATA: begin
          if (rx_xfer) begin
            shreg <= shreg_next;
            if (cnt == LAST_BYTE) begin
              rx_ready <= 1'b0;
              state    <= EXEC;
              // wen/addr/data_in are registered here so they are stable in EXEC
              if (addr_status(addr_byte, 1'b1) == ST_OK) begin
                wen     <= 1'b1;
                addr    <= addr_byte[ADDR_WIDTH-1:0];
                data_in <= shreg_next;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        EXEC: begin
          if (exec_status != ST_OK || is_write) begin
            tx_data  <= exec_status;
            tx_valid <= 1'b1;
            state    <= SEND_STATUS;
          end else if (READ_LATENCY == 0) begin
            shreg    <= data_out;
            rd_ok    <= 1'b1;
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= SEND_STATUS;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          if (cnt == LAT_LAST) begin
            shreg    <= data_out;
            rd_ok    <= 1'b1;
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= SEND_STATUS;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        SEND_STATUS: begin
          if (tx_ready) begin
            if (rd_ok) begin
              tx_data <= shreg[MEMORY_WIDTH-1 -: 8];
              shreg   <= shreg << 8;
              cnt     <= '0;
              state   <= SEND_DATA;
            end else begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        SEND_DATA: begin
          if (tx_ready) begin
            if (cnt == LAST_BYTE) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              rd_ok    <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data <= shreg[MEMORY_WIDTH-1 -: 8];
              shreg   <= shreg << 8;
              cnt     <= cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_settings_host_bridge.sv
`timescale 1ns/1ps
// Directed testbench for settings_host_bridge with a small settings memory
// model: ROM word i reads as i, RAM words at 16..31 are writable, one-cycle
// registered read latency.
module tb_settings_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  addr;
  logic        wen;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int w0;

  logic [31:0] ram [16];

  always #5 clk = ~clk;

  settings_host_bridge #(
    .MEMORY_WIDTH(32),
    .ROM_MEMORY_LENGTH(16),
    .RAM_MEMORY_LENGTH(16),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .addr(addr),
    .wen(wen),
    .data_in(data_in),
    .data_out(data_out),
    .busy(busy)
  );

  // settings memory model
  always @(posedge clk) begin
    if (wen) begin
      wen_cnt <= wen_cnt + 1;
      if (addr >= 5'd16) ram[addr[3:0]] <= data_in;
    end
    data_out <= (addr < 5'd16) ? 32'(addr) : ram[addr[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: rx_ready low for %0d cycles, byte %h", n, b);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, input int stall, input string tag);
    int n = 0;
    logic [7:0] first;
    tx_ready = 1'b0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: tx_valid low for %0d cycles", tag, n);
      b = '0;
      return;
    end
    first = tx_data;
    repeat (stall) begin
      @(negedge clk);
      check({tag, " hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, first});
    end
    tx_ready = 1'b1;
    b = tx_data;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic expect_resp(input logic [7:0] st, input logic has_data, input logic [31:0] word,
                             input int stall, input string tag);
    logic [7:0] b;
    recv_byte(b, stall, {tag, " status"});
    check({tag, " status"}, 32'(b), 32'(st));
    if (has_data) begin
      for (int unsigned i = 0; i < 4; i++) begin
        recv_byte(b, stall, {tag, " data"});
        check({tag, " data"}, 32'(b), 32'(word[31 - 8*i -: 8]));
      end
    end
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [31:0] w);
    send_byte(8'h02);
    send_byte(a);
    for (int unsigned i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8]);
  endtask

  task automatic read_frame(input logic [7:0] a);
    send_byte(8'h01);
    send_byte(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, " tx_data"},  32'(tx_data),  32'd0);
    check({tag, " wen"},      32'(wen),      32'd0);
    check({tag, " addr"},     32'(addr),     32'd0);
    check({tag, " data_in"},  data_in,       32'd0);
    check({tag, " busy"},     32'(busy),     32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready after reset", 32'(rx_ready), 32'd1);

    // write 0x10 to RAM address 16
    w0 = wen_cnt;
    write_frame(8'h10, 32'h0000_0010);
    check("wr wen", 32'(wen), 32'd1);
    check("wr addr", 32'(addr), 32'd16);
    check("wr data_in", data_in, 32'h10);
    expect_resp(8'hA0, 1'b0, 32'd0, 0, "wr16");
    check("wr16 wen pulses", 32'(wen_cnt - w0), 32'd1);
    check("ram_data_out_0", ram[0], 32'd16);

    // read ROM address 3
    w0 = wen_cnt;
    read_frame(8'h03);
    check("rd3 addr in exec", 32'(addr), 32'd3);
    expect_resp(8'hA0, 1'b1, 32'h0000_0003, 0, "rd3");
    check("rd3 wen pulses", 32'(wen_cnt - w0), 32'd0);

    // write to ROM is rejected after consuming the data bytes
    w0 = wen_cnt;
    write_frame(8'h02, 32'h1122_3344);
    expect_resp(8'hE3, 1'b0, 32'd0, 0, "romwr");
    check("romwr wen pulses", 32'(wen_cnt - w0), 32'd0);

    // out-of-range read
    read_frame(8'h20);
    expect_resp(8'hE2, 1'b0, 32'd0, 0, "badaddr");

    // bad command, then a normal read
    send_byte(8'h7F);
    expect_resp(8'hE1, 1'b0, 32'd0, 0, "badcmd");
    read_frame(8'h05);
    expect_resp(8'hA0, 1'b1, 32'h0000_0005, 0, "rd5");

    // backpressure on read data
    write_frame(8'h10, 32'h1234_5678);
    expect_resp(8'hA0, 1'b0, 32'd0, 0, "wr1234");
    read_frame(8'h10);
    expect_resp(8'hA0, 1'b1, 32'h1234_5678, 5, "bp");

    // reset after the 2nd data byte of a write
    w0 = wen_cnt;
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset rx_ready", 32'(rx_ready), 32'd1);
    check("midreset wen pulses", 32'(wen_cnt - w0), 32'd0);
    write_frame(8'h11, 32'hCAFE_BABE);
    expect_resp(8'hA0, 1'b0, 32'd0, 0, "wr17");
    check("wr17 wen pulses", 32'(wen_cnt - w0), 32'd1);
    read_frame(8'h11);
    expect_resp(8'hA0, 1'b1, 32'hCAFE_BABE, 0, "rd17");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
